// File: rtl/alu_bcd_display.sv
// alu_bcd_display: serial double-dabble conversion of an 8-bit result shown on a 4-digit multiplexed 7-seg display
module alu_bcd_display #(
   parameter int SCAN_DIV = 100_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  result,
   output logic [11:0] bcd_out,
   output logic        bcd_valid,
   output logic        busy,
   output logic        conv_done,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);
   localparam int CW = $clog2(SCAN_DIV);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state_q, state_d;
   logic [7:0] shadow_q, shadow_d, shift_q, shift_d;
   logic [11:0] scratch_q, scratch_d, bcd_q, bcd_d, adj;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic pending_q, pending_d, valid_q, valid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] an_q, an_d, digit;
   logic [6:0] seg_q, seg_d;
   logic blank;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return n >= 4'd5 ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   assign adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

   // conversion FSM: capture on change or pending, eight shift-add steps, then publish
   always_comb begin
      state_d = state_q;
      shadow_d = shadow_q;
      shift_d = shift_q;
      scratch_d = scratch_q;
      bitcnt_d = bitcnt_q;
      pending_d = pending_q;
      bcd_d = bcd_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: if (result != shadow_q || pending_q) begin
            shadow_d = result;
            shift_d = result;
            scratch_d = '0;
            bitcnt_d = '0;
            pending_d = 1'b0;
            state_d = SHIFT;
         end
         SHIFT: begin
            scratch_d = {adj[10:0], shift_q[7]};
            shift_d = {shift_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 3'd1;
            state_d = bitcnt_q == 3'd7 ? DONE : SHIFT;
         end
         DONE: begin
            bcd_d = scratch_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // scan timing and registered anode/segment drive, fed only from the published digits
   always_comb begin
      cnt_d = cnt_q == CW'(SCAN_DIV - 1) ? '0 : cnt_q + CW'(1);
      idx_d = cnt_q == CW'(SCAN_DIV - 1) ? idx_q + 2'd1 : idx_q;
      digit = idx_q == 2'd0 ? bcd_q[3:0] : idx_q == 2'd1 ? bcd_q[7:4] : bcd_q[11:8];
      blank = !valid_q || idx_q == 2'd3 || (idx_q == 2'd1 && bcd_q[11:4] == 8'h00)
              || (idx_q == 2'd2 && bcd_q[11:8] == 4'h0);
      an_d = blank ? 4'b1111 : ~(4'b0001 << idx_q);
      seg_d = blank ? 7'b1111111 : seg_code(digit);
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shadow_q <= '0;
         shift_q <= '0;
         scratch_q <= '0;
         bitcnt_q <= '0;
         pending_q <= 1'b1;
         bcd_q <= '0;
         valid_q <= 1'b0;
         cnt_q <= '0;
         idx_q <= '0;
         an_q <= 4'b1111;
         seg_q <= 7'b1111111;
      end else begin
         state_q <= state_d;
         shadow_q <= shadow_d;
         shift_q <= shift_d;
         scratch_q <= scratch_d;
         bitcnt_q <= bitcnt_d;
         pending_q <= pending_d;
         bcd_q <= bcd_d;
         valid_q <= valid_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         an_q <= an_d;
         seg_q <= seg_d;
      end
   end

   assign bcd_out = bcd_q;
   assign bcd_valid = valid_q;
   assign busy = state_q != IDLE;
   assign conv_done = state_q == DONE;
   assign an = an_q;
   assign seg = seg_q;
   assign dp = 1'b1;
endmodule
